sdm_cic_decimator: RTL and testbench
====================================

Name: sdm_cic_decimator

Overview:
- Bitstream decoder for the iCESDM sigma-delta modulator.
- Takes the modulator's 1-bit output stream, qualified by its sample strobe, and converts it to multi-bit PCM samples.
- Uses a 3rd-order CIC (Hogenauer) decimation filter with decimation ratio R = 2^LOG2R.
- Sits between the modulator's output flip-flop and the downstream sample consumer (UART/SPI readout).

Parameters:
- LOG2R, 8, log2 of decimation ratio R; legal range 2..10.
- ACC_W (localparam), 3*LOG2R+1, integrator/comb width; holds full-scale R^3 exactly.
- OUT_W (localparam), ACC_W (or ACC_W-1 with SDM_CIC_SATURATE_EN), width of o_data.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_bit  input  1  modulator bitstream sample; 1 maps to +1, 0 maps to 0 (unsigned).
- i_bit_valid  input  1  one-cycle strobe marking i_bit as a new modulator sample; may be high every cycle.
- o_data  output  OUT_W  decimated sample, unsigned, range 0..R^3.
- o_valid  output  1  one-cycle pulse; o_data is updated on this cycle.

Behaviour:
- Interface: single clock i_clk. Reset i_rst is synchronous and active-high. On reset, all of the following clear to 0: integrators I1..I3, decimation counter, comb delays D1..D3, comb stage registers, o_data and o_valid.
- Reset mid-operation discards any partial decimation window and any comb result in flight; no o_valid pulse is issued for a discarded result.
- Integrators run only on cycles with i_bit_valid=1; otherwise they hold. The update is pipelined and uses the old values: I1 <= I1+x, I2 <= I2+I1, I3 <= I3+I2.
- Integrator arithmetic is modulo 2^ACC_W. Wrap-around is intentional and is not flagged; comb differencing recovers the exact result.
- Decimation counter cnt, width LOG2R:
  - increments on each i_bit_valid;
  - wraps from R-1 to 0;
  - when cnt==R-1 and i_bit_valid, a decimation strobe dec_stb is registered for the next cycle and I3 is captured into S.
- Comb pipeline: three registered stages, each advancing on its predecessor's valid pulse.
  - C1 = S - D1, then D1 <= S;
  - C2 = C1 - D2, then D2 <= C1;
  - C3 = C2 - D3, then D3 <= C2;
  - all arithmetic modulo 2^ACC_W.
- Output: o_data <= C3 and o_valid=1 for exactly one cycle.
- Latency: o_valid pulses exactly 4 i_clk cycles after the edge that consumed the R-th valid sample of a window.
- Throughput: R>=4 guarantees the comb pipeline has drained before the next dec_stb, so no backpressure exists. o_data holds its value between pulses.
- Warm-up: the first 3 outputs after reset are transient. From the 4th output onward, o_data is exact for a stationary input.
- Simultaneous events: i_rst has priority over i_bit_valid and all pipeline strobes on the same edge.

Optional Feature:
- Macro: SDM_CIC_SATURATE_EN.
- Defined:
  - OUT_W = ACC_W-1;
  - the final stage clamps C3 >= 2^(3*LOG2R) to 2^(3*LOG2R)-1, so an all-ones full-scale input (R^3) reads 2^(3*LOG2R)-1;
  - all other values pass unchanged;
  - the port packs into a power-of-two-friendly width (24 bits at LOG2R=8).
- Undefined: OUT_W = ACC_W, no clamp, and full-scale reads exactly R^3.

Decomposition:
- Package sdm_pkg:
  - CIC_ORDER=3;
  - function cic_acc_w(log2r) returning 3*log2r+1;
  - function cic_out_w(log2r, sat);
  - a comment-free default LOG2R constant shared with the modulator.
- One sub-module, cic_comb_stage:
  - parameter W;
  - ports i_clk, i_rst, i_valid, i_x, o_valid, o_y;
  - contains the delay register and subtractor;
  - instantiated 3 times in a chain.
- Integrators and counter are kept inline.

Test Plan:
- Reset then all-zeros bitstream, LOG2R=8, i_bit_valid every cycle -> every o_valid pulse has o_data=0; pulses spaced exactly 256 cycles apart.
- All-ones bitstream, LOG2R=2 (R=4) -> outputs 4 onward equal 64 (ACC_W=7), or 63 with SDM_CIC_SATURATE_EN.
- All-ones bitstream, LOG2R=8 -> outputs 4 onward equal 16777216, or 16777215 with SDM_CIC_SATURATE_EN. Integrators wrap internally without error.
- Alternating 1,0,1,0 bitstream, LOG2R=8 -> outputs 4 onward equal exactly 8388608 (R^3/2).
- i_bit_valid every 3rd cycle, all-ones, LOG2R=2 -> o_valid pulses every 12 cycles, each 4 cycles after the 4th valid sample of its window; values match the dense case.
- Assert i_rst for 1 cycle mid-window after 100 samples, LOG2R=8 -> o_valid=0 and o_data=0 the next cycle; no pulse for the aborted window. The next pulse comes 256 valid samples plus 4 cycles after reset release.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared constants and width helpers for the iCESDM bitstream decimator.
// Optional feature macro: SDM_CIC_SATURATE_EN (drops one output bit and clamps full scale).
package sdm_pkg;

   localparam int unsigned CIC_ORDER = 3;

   localparam int unsigned SDM_LOG2R = 8;

`ifdef SDM_CIC_SATURATE_EN
   localparam bit CIC_SAT_EN = 1'b1;
`else
   localparam bit CIC_SAT_EN = 1'b0;
`endif

   // Integrator/comb width: holds R^3 = 2^(3*log2r) exactly.
   function automatic int unsigned cic_acc_w(input int unsigned log2r);
      return CIC_ORDER * log2r + 1;
   endfunction

   // Output width: one bit narrower when full scale is clamped.
   function automatic int unsigned cic_out_w(input int unsigned log2r, input bit sat);
      return sat ? cic_acc_w(log2r) - 1 : cic_acc_w(log2r);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x_prev, advancing only on the input valid pulse.
module cic_comb_stage #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_x,
   output logic         o_valid,
   output logic [W-1:0] o_y
);

   logic [W-1:0] dly_q, dly_d;
   logic [W-1:0] y_q,   y_d;
   logic         vld_q, vld_d;

   // Difference against the previous sample and remember the current one.
   always_comb begin
      dly_d = dly_q;
      y_d   = y_q;
      vld_d = 1'b0;
      if (i_valid) begin
         y_d   = i_x - dly_q;
         dly_d = i_x;
         vld_d = 1'b1;
      end
   end

   // Stage registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dly_q <= '0;
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   assign o_y     = y_q;
   assign o_valid = vld_q;

endmodule

// File: rtl/sdm_cic_decimator.sv
// 3rd-order CIC decimator turning the iCESDM 1-bit stream into unsigned PCM.
// Optional feature macro: SDM_CIC_SATURATE_EN (clamps R^3 to 2^(3*LOG2R)-1, OUT_W = ACC_W-1).
module sdm_cic_decimator
   import sdm_pkg::*;
#(
   parameter  int unsigned LOG2R = SDM_LOG2R,
   localparam int unsigned OUT_W = cic_out_w(LOG2R, CIC_SAT_EN)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_bit,
   input  logic             i_bit_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_valid
);

   localparam int unsigned ACC_W = cic_acc_w(LOG2R);

   logic [ACC_W-1:0] i1_q, i1_d;
   logic [ACC_W-1:0] i2_q, i2_d;
   logic [ACC_W-1:0] i3_q, i3_d;
   logic [ACC_W-1:0] s_q,  s_d;
   logic [LOG2R-1:0] cnt_q, cnt_d;
   logic             dec_stb_q, dec_stb_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   logic             c1_vld, c2_vld, c3_vld;
   logic [ACC_W-1:0] c1_y, c2_y, c3_y;

   // Pipelined integrators (old values, modulo 2^ACC_W) and decimation counter.
   always_comb begin
      i1_d      = i1_q;
      i2_d      = i2_q;
      i3_d      = i3_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      dec_stb_d = 1'b0;
      if (i_bit_valid) begin
         i1_d  = i1_q + ACC_W'(i_bit);
         i2_d  = i2_q + i1_q;
         i3_d  = i3_q + i2_q;
         cnt_d = cnt_q + LOG2R'(1);
         if (cnt_q == '1) begin
            dec_stb_d = 1'b1;
            s_d       = i3_q;
         end
      end
   end

   // Integrator, counter and capture registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         i1_q      <= '0;
         i2_q      <= '0;
         i3_q      <= '0;
         s_q       <= '0;
         cnt_q     <= '0;
         dec_stb_q <= 1'b0;
      end else begin
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         i3_q      <= i3_d;
         s_q       <= s_d;
         cnt_q     <= cnt_d;
         dec_stb_q <= dec_stb_d;
      end
   end

   cic_comb_stage #(.W(ACC_W)) u_comb1 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (dec_stb_q),
      .i_x     (s_q),
      .o_valid (c1_vld),
      .o_y     (c1_y)
   );

   cic_comb_stage #(.W(ACC_W)) u_comb2 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (c1_vld),
      .i_x     (c1_y),
      .o_valid (c2_vld),
      .o_y     (c2_y)
   );

   cic_comb_stage #(.W(ACC_W)) u_comb3 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (c2_vld),
      .i_x     (c2_y),
      .o_valid (c3_vld),
      .o_y     (c3_y)
   );

   // Output stage: latch the comb result (optionally clamped) with a one-cycle valid.
   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (c3_vld) begin
         valid_d = 1'b1;
`ifdef SDM_CIC_SATURATE_EN
         data_d  = c3_y[ACC_W-1] ? {OUT_W{1'b1}} : c3_y[OUT_W-1:0];
`else
         data_d  = c3_y;
`endif
      end
   end

   // Output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Self-checking bench: two decimators (R=256 and R=4) fed periodic bit patterns.
module tb_sdm_cic_decimator;

`ifdef SDM_CIC_SATURATE_EN
   localparam int OUT_A = 24;
   localparam int OUT_B = 6;
   localparam logic [31:0] FS_A = 32'd16777215;
   localparam logic [31:0] FS_B = 32'd63;
`else
   localparam int OUT_A = 25;
   localparam int OUT_B = 7;
   localparam logic [31:0] FS_A = 32'd16777216;
   localparam logic [31:0] FS_B = 32'd64;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_a = 1'b1, bit_a = 1'b0, vld_a = 1'b0;
   logic             rst_b = 1'b1, bit_b = 1'b0, vld_b = 1'b0;
   logic [OUT_A-1:0] data_a;
   logic [OUT_B-1:0] data_b;
   logic             valid_a, valid_b;

   sdm_cic_decimator #(.LOG2R(8)) dut_a (
      .i_clk       (clk),
      .i_rst       (rst_a),
      .i_bit       (bit_a),
      .i_bit_valid (vld_a),
      .o_data      (data_a),
      .o_valid     (valid_a)
   );

   sdm_cic_decimator #(.LOG2R(2)) dut_b (
      .i_clk       (clk),
      .i_rst       (rst_b),
      .i_bit       (bit_b),
      .i_bit_valid (vld_b),
      .o_data      (data_b),
      .o_valid     (valid_b)
   );

   typedef struct {
      bit          chk;
      logic [31:0] val;
      int          due;
   } exp_t;

   typedef struct {
      int          sel;
      logic [3:0]  pat;
      int          stride;
      int          nwin;
      logic [31:0] expv;
   } vec_t;

   exp_t        qa[$];
   exp_t        qb[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          rr[2]   = '{256, 4};
   int          win[2]  = '{0, 0};
   int          nout[2] = '{0, 0};
   logic [31:0] steady[2];
   vec_t        vecs[10];

   // Compare one DUT's output against the head of its scoreboard queue.
   task automatic chk_out(input int sel, input logic v, input logic [31:0] d);
      exp_t e;
      int   n;
      if (v !== 1'b1) return;
      n = (sel == 0) ? qa.size() : qb.size();
      total++;
      if (n == 0) begin
         bad++;
         $display("FAIL spurious_pulse dut%0d cyc=%0d data=%0d, required no pulse", sel, cyc, d);
         return;
      end
      e = (sel == 0) ? qa.pop_front() : qb.pop_front();
      if (e.due != cyc) begin
         bad++;
         $display("FAIL pulse_time dut%0d got cycle %0d required %0d", sel, cyc, e.due);
      end
      if (e.chk) begin
         total++;
         if (d !== e.val) begin
            bad++;
            $display("FAIL pulse_data dut%0d cyc=%0d got %0d required %0d", sel, cyc, d, e.val);
         end
      end
   endtask

   // Drive one clock of stimulus to the selected DUT, update the model, check at negedge.
   task automatic step(input int sel, input logic r, input logic b, input logic v);
      exp_t e;
      rst_a = (sel == 0) ? r : 1'b0;
      bit_a = (sel == 0) ? b : 1'b0;
      vld_a = (sel == 0) ? v : 1'b0;
      rst_b = (sel == 1) ? r : 1'b0;
      bit_b = (sel == 1) ? b : 1'b0;
      vld_b = (sel == 1) ? v : 1'b0;
      @(posedge clk);
      cyc++;
      if (r) begin
         win[sel]  = 0;
         nout[sel] = 0;
         if (sel == 0) qa.delete(); else qb.delete();
      end else if (v) begin
         win[sel]++;
         if (win[sel] == rr[sel]) begin
            win[sel] = 0;
            e.chk = (nout[sel] >= 3);
            e.val = steady[sel];
            e.due = cyc + 4;
            if (sel == 0) qa.push_back(e); else qb.push_back(e);
            nout[sel]++;
         end
      end
      @(negedge clk);
      chk_out(0, valid_a, 32'(data_a));
      chk_out(1, valid_b, 32'(data_b));
   endtask

   task automatic do_reset(input int sel);
      step(sel, 1'b1, 1'b0, 1'b0);
      step(sel, 1'b1, 1'b0, 1'b0);
   endtask

   // n valid samples from a 4-bit periodic pattern, one valid every `stride` cycles.
   task automatic feed(input int sel, input logic [3:0] pat, input int n, input int stride);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < stride - 1; k++) step(sel, 1'b0, 1'b0, 1'b0);
         step(sel, 1'b0, pat[2'(3 - (i % 4))], 1'b1);
      end
   endtask

   // Idle long enough for pending pulses, then require the scoreboard to be empty.
   task automatic drain(input int sel, input string tag);
      int n;
      for (int k = 0; k < 8; k++) step(sel, 1'b0, 1'b0, 1'b0);
      n = (sel == 0) ? qa.size() : qb.size();
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL missing_pulse %s dut%0d got %0d pulses outstanding, required 0", tag, sel, n);
         if (sel == 0) qa.delete(); else qb.delete();
      end
   endtask

   initial begin
      vecs[0] = '{0, 4'b0000, 1, 5, 32'd0};
      vecs[1] = '{0, 4'b1111, 1, 5, FS_A};
      vecs[2] = '{0, 4'b1010, 1, 5, 32'd8388608};
      vecs[3] = '{0, 4'b1000, 1, 5, 32'd4194304};
      vecs[4] = '{0, 4'b1110, 1, 5, 32'd12582912};
      vecs[5] = '{1, 4'b1111, 1, 8, FS_B};
      vecs[6] = '{1, 4'b1010, 1, 8, 32'd32};
      vecs[7] = '{1, 4'b0100, 1, 8, 32'd16};
      vecs[8] = '{1, 4'b1111, 3, 8, FS_B};
      vecs[9] = '{1, 4'b0000, 2, 8, 32'd0};

      steady[0] = '0;
      steady[1] = '0;

      // Reset state of both instances.
      do_reset(0);
      do_reset(1);
      total += 4;
      if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got %b required 0", valid_a); end
      if (data_a !== '0)    begin bad++; $display("FAIL reset_data_a got %0d required 0", data_a); end
      if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got %b required 0", valid_b); end
      if (data_b !== '0)    begin bad++; $display("FAIL reset_data_b got %0d required 0", data_b); end

      // Table of stationary patterns: steady value = popcount/4 * R^3 from output 4 on.
      for (int t = 0; t < 10; t++) begin
         steady[vecs[t].sel] = vecs[t].expv;
         do_reset(vecs[t].sel);
         feed(vecs[t].sel, vecs[t].pat, vecs[t].nwin * rr[vecs[t].sel], vecs[t].stride);
         drain(vecs[t].sel, $sformatf("vec%0d", t));
      end

      // Reset 100 samples into a window: outputs clear, aborted window yields nothing.
      steady[0] = FS_A;
      do_reset(0);
      feed(0, 4'b1111, 5 * 256 + 100, 1);
      step(0, 1'b1, 1'b0, 1'b0);
      total += 2;
      if (valid_a !== 1'b0) begin bad++; $display("FAIL midreset_valid got %b required 0", valid_a); end
      if (data_a !== '0)    begin bad++; $display("FAIL midreset_data got %0d required 0", data_a); end
      feed(0, 4'b1111, 256, 1);
      drain(0, "after_midreset");

      // Reset while a comb result is in flight: that result must be discarded.
      steady[1] = FS_B;
      do_reset(1);
      feed(1, 4'b1111, 16, 1);
      step(1, 1'b1, 1'b0, 1'b0);
      drain(1, "inflight_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
